pipe_ctrl: RTL and testbench

Central hazard and redirect controller for the 5-stage core. It generates the per-register stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Every pipeline register applies these controls with the same priority: flush loads zero, else stall holds, else load. The controller also sequences PC redirects from branch mispredicts and traps into the fetch unit, holds the pipeline while a multi-cycle mul/div runs, and counts stall cycles.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl_redirect.sv | 58 +++++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices and FSM encodings for the pipeline controller
package pipe_ctrl_pkg;

  localparam int PIPE_IF_ID  = 0;
  localparam int PIPE_ID_EX  = 1;
  localparam int PIPE_EX_MEM = 2;
  localparam int PIPE_MEM_WB = 3;
  localparam int PIPE_REGS   = 4;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } redir_state_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard inputs and stall/flush/redirect outputs of the pipeline controller
interface pipe_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  logic             ifu_busy_i;
  logic             lsu_busy_i;
  logic             load_use_i;
  logic             bp_miss_i;
  logic [XLEN-1:0]  bp_target_i;
  logic             muldiv_start_i;
  logic             muldiv_done_i;
  logic             trap_i;
  logic [XLEN-1:0]  trap_pc_i;

  logic             pc_stall_o;
  logic [3:0]       stall_o;
  logic [3:0]       flush_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             muldiv_kill_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output ifu_busy_i, lsu_busy_i, load_use_i, bp_miss_i, bp_target_i,
    output muldiv_start_i, muldiv_done_i, trap_i, trap_pc_i,
    input  pc_stall_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o,
    input  muldiv_kill_o, stall_cnt_o
  );

  modport slave (
    input  ifu_busy_i, lsu_busy_i, load_use_i, bp_miss_i, bp_target_i,
    input  muldiv_start_i, muldiv_done_i, trap_i, trap_pc_i,
    output pc_stall_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o,
    output muldiv_kill_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_redirect.sv
// rtl/pipe_ctrl_redirect.sv - redirect FSM holding the fetch target until fetch accepts it
module pipe_ctrl_redirect
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_busy,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            bp_take,
  input  logic [XLEN-1:0] bp_target,
  output logic            pending,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  redir_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (trap) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_pc;
          end else if (bp_take) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= bp_target;
          end
        end
        REDIR: begin
          // A trap supersedes the pending target even in the acceptance cycle.
          if (trap) begin
            redirect_pc <= trap_pc;
          end else if (!ifu_busy) begin
            state          <= RUN;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= RUN;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pending = (state == REDIR);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard priority, mul/div hold, redirect sequencing and stall counting
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  md_state_t        md_state;
  logic             redir_pending;
  logic             md_hold;
  logic             bp_take;
  logic             pc_stall;
  logic [3:0]       stall;
  logic [3:0]       flush;
  logic [CNT_W-1:0] stall_cnt;

  // The mul/div hold drops in the done cycle so EX advances with the result.
  assign md_hold = (md_state == MD_BUSY) && !bus.muldiv_done_i;
  assign bp_take = bus.bp_miss_i && !bus.lsu_busy_i && !redir_pending;

  always_comb begin
    pc_stall = 1'b0;
    stall    = '0;
    flush    = '0;
    if (bus.trap_i) begin
      flush[PIPE_IF_ID]  = 1'b1;
      flush[PIPE_ID_EX]  = 1'b1;
      flush[PIPE_EX_MEM] = 1'b1;
    end
    if (bus.lsu_busy_i) begin
      pc_stall           = 1'b1;
      stall[PIPE_IF_ID]  = 1'b1;
      stall[PIPE_ID_EX]  = 1'b1;
      stall[PIPE_EX_MEM] = 1'b1;
      flush[PIPE_MEM_WB] = 1'b1;
    end else begin
      if (redir_pending) begin
        pc_stall          = 1'b1;
        flush[PIPE_IF_ID] = 1'b1;
      end
      if (md_hold) begin
        pc_stall           = 1'b1;
        stall[PIPE_IF_ID]  = 1'b1;
        stall[PIPE_ID_EX]  = 1'b1;
        flush[PIPE_EX_MEM] = 1'b1;
      end
      if (bp_take) begin
        flush[PIPE_IF_ID] = 1'b1;
        flush[PIPE_ID_EX] = 1'b1;
      end
      if (bus.load_use_i) begin
        pc_stall          = 1'b1;
        stall[PIPE_IF_ID] = 1'b1;
        flush[PIPE_ID_EX] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_state <= IDLE;
    end else begin
      case (md_state)
        IDLE: begin
          // A start that is flushed, held in EX, or finishes at once never busies the unit.
          if (bus.muldiv_start_i && !bus.lsu_busy_i && !bus.muldiv_done_i && !bus.trap_i) begin
            md_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (bus.muldiv_done_i || bus.trap_i) begin
            md_state <= IDLE;
          end
        end
        default: md_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  pipe_ctrl_redirect #(
    .XLEN(XLEN)
  ) u_redirect (
    .clk           (clk),
    .rst           (rst),
    .ifu_busy      (bus.ifu_busy_i),
    .trap          (bus.trap_i),
    .trap_pc       (bus.trap_pc_i),
    .bp_take       (bp_take),
    .bp_target     (bus.bp_target_i),
    .pending       (redir_pending),
    .redirect_valid(bus.redirect_valid_o),
    .redirect_pc   (bus.redirect_pc_o)
  );

  assign bus.pc_stall_o    = pc_stall;
  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.muldiv_kill_o = bus.trap_i && (md_state == MD_BUSY);
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for the pipeline hazard/redirect controller
module tb_pipe_ctrl;

  typedef struct {
    string       tag;
    bit          pcs;
    bit          rv;
    bit          kill;
    bit [3:0]    st;
    bit [3:0]    fl;
    bit [63:0]   rpc;
    bit [31:0]   cnt;
  } exp_t;

  localparam logic [63:0] T_BP1  = 64'h8000_0100;
  localparam logic [63:0] T_BP2  = 64'h8000_0200;
  localparam logic [63:0] T_TR1  = 64'h8000_0004;
  localparam logic [63:0] T_TR2  = 64'h8000_0040;
  localparam logic [63:0] T_BP3  = 64'h8000_0300;
  localparam logic [63:0] T_BP4  = 64'h8000_0500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit [31:0] cnt_model = 0;

  pipe_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();

  pipe_ctrl #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // in: {load_use, bp_miss, md_start, md_done, trap, lsu_busy, ifu_busy}; e: {pc_stall, redirect_valid, kill}
  task automatic drive(input string tag, input bit [6:0] in, input logic [63:0] bt,
                       input logic [63:0] tp, input bit [2:0] e, input bit [3:0] st,
                       input bit [3:0] fl, input logic [63:0] rpc);
    exp_t x;
    @(posedge clk);
    #1;
    bus.load_use_i     = in[6];
    bus.bp_miss_i      = in[5];
    bus.muldiv_start_i = in[4];
    bus.muldiv_done_i  = in[3];
    bus.trap_i         = in[2];
    bus.lsu_busy_i     = in[1];
    bus.ifu_busy_i     = in[0];
    bus.bp_target_i    = bt;
    bus.trap_pc_i      = tp;
    x.tag  = tag;
    x.pcs  = e[2];
    x.rv   = e[1];
    x.kill = e[0];
    x.st   = st;
    x.fl   = fl;
    x.rpc  = rpc;
    x.cnt  = cnt_model;
    if (e[2]) cnt_model = cnt_model + 1;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check({x.tag, ".pc_stall"}, 64'(bus.pc_stall_o), 64'(x.pcs));
      check({x.tag, ".stall"}, 64'(bus.stall_o), 64'(x.st));
      check({x.tag, ".flush"}, 64'(bus.flush_o), 64'(x.fl));
      check({x.tag, ".rv"}, 64'(bus.redirect_valid_o), 64'(x.rv));
      check({x.tag, ".rpc"}, bus.redirect_pc_o, x.rpc);
      check({x.tag, ".kill"}, 64'(bus.muldiv_kill_o), 64'(x.kill));
      check({x.tag, ".cnt"}, 64'(bus.stall_cnt_o), 64'(x.cnt));
    end
  end

  initial begin
    bus.load_use_i = 0; bus.bp_miss_i = 0; bus.muldiv_start_i = 0; bus.muldiv_done_i = 0;
    bus.trap_i = 0; bus.lsu_busy_i = 0; bus.ifu_busy_i = 0;
    bus.bp_target_i = '0; bus.trap_pc_i = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst.pc_stall", 64'(bus.pc_stall_o), 64'd0);
    check("rst.flush", 64'(bus.flush_o), 64'd0);
    check("rst.rv", 64'(bus.redirect_valid_o), 64'd0);
    check("rst.rpc", bus.redirect_pc_o, 64'd0);
    check("rst.cnt", 64'(bus.stall_cnt_o), 64'd0);
    rst = 1'b1;

    drive("idle0",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, 64'd0);
    drive("lu",     7'b1000000, 0, 0, 3'b100, 4'b0001, 4'b0010, 64'd0);
    drive("lu_end", 7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, 64'd0);

    drive("bp_T",   7'b0100000, T_BP1, 0, 3'b000, 4'b0000, 4'b0011, 64'd0);
    drive("bp_T1",  7'b0000001, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP1);
    drive("bp_T2",  7'b0000001, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP1);
    drive("bp_T3",  7'b0000001, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP1);
    drive("bp_T4",  7'b0000000, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP1);
    drive("bp_T5",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_BP1);

    drive("trbp_T", 7'b0100100, T_BP2, T_TR1, 3'b000, 4'b0000, 4'b0111, T_BP1);
    drive("trbp_A", 7'b0000000, 0, 0, 3'b110, 4'b0000, 4'b0001, T_TR1);
    drive("trbp_E", 7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR1);

    drive("md_st",  7'b0010000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR1);
    for (int i = 0; i < 4; i++)
      drive($sformatf("md_b%0d", i), 7'b0000000, 0, 0, 3'b100, 4'b0011, 4'b0100, T_TR1);
    drive("md_done", 7'b0001000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR1);
    drive("md_aft",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR1);

    drive("mk_st",   7'b0010000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR1);
    drive("mk_b",    7'b0000000, 0, 0, 3'b100, 4'b0011, 4'b0100, T_TR1);
    drive("mk_trap", 7'b0000101, 0, T_TR2, 3'b101, 4'b0011, 4'b0111, T_TR1);
    drive("mk_r1",   7'b0000001, 0, 0, 3'b110, 4'b0000, 4'b0001, T_TR2);
    drive("mk_r2",   7'b0000000, 0, 0, 3'b110, 4'b0000, 4'b0001, T_TR2);
    drive("mk_end",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_TR2);

    drive("lsbp_0",  7'b0100010, T_BP3, 0, 3'b100, 4'b0111, 4'b1000, T_TR2);
    drive("lsbp_1",  7'b0100010, T_BP3, 0, 3'b100, 4'b0111, 4'b1000, T_TR2);
    drive("lsbp_tk", 7'b0100000, T_BP3, 0, 3'b000, 4'b0000, 4'b0011, T_TR2);
    drive("lsbp_a",  7'b0000000, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP3);
    drive("lsbp_e",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_BP3);

    drive("mdsd",    7'b0011000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_BP3);
    drive("mdsd_n",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_BP3);
    drive("mdls",    7'b0010010, 0, 0, 3'b100, 4'b0111, 4'b1000, T_BP3);
    drive("mdls_n",  7'b0000000, 0, 0, 3'b000, 4'b0000, 4'b0000, T_BP3);

    drive("rr_bp",   7'b0100000, T_BP4, 0, 3'b000, 4'b0000, 4'b0011, T_BP3);
    drive("rr_r",    7'b0000001, 0, 0, 3'b110, 4'b0000, 4'b0001, T_BP4);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rr.rv", 64'(bus.redirect_valid_o), 64'd0);
    check("rr.rpc", bus.redirect_pc_o, 64'd0);
    check("rr.pc_stall", 64'(bus.pc_stall_o), 64'd0);
    check("rr.flush", 64'(bus.flush_o), 64'd0);
    check("rr.cnt", 64'(bus.stall_cnt_o), 64'd0);
    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
